// File: rtl/branch_sched.sv
// In-order branch scheduler: allocates per-thread entries at issue, takes out-of-order
// resolutions from execute, and presents/retires the oldest entry to the PC stage.
module branch_sched #(
    parameter int XLEN    = 32,
    parameter int THREADS = 8,
    parameter int TID_W   = 3,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               alloc_valid_i,
    input  logic [TID_W-1:0]   alloc_tid_i,
    output logic               alloc_ready_o,
    input  logic               res_valid_i,
    input  logic [TID_W-1:0]   res_tid_i,
    input  logic               res_taken_i,
    input  logic [XLEN-1:0]    res_target_i,
    output logic               res_err_o,
    output logic               br_fifo_empty_o,
    output logic [TID_W-1:0]   br_thread_id_o,
    output logic               br_valid_o,
    output logic               br_true_o,
    output logic [XLEN-1:0]    br_pc_o,
    input  logic               br_ack_i,
    output logic [THREADS-1:0] pending_o,
    output logic [TID_W:0]     count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TID_W:0] DEPTH_C = (TID_W+1)'(DEPTH);

    logic [TID_W-1:0]   ent_tid [DEPTH];
    logic [XLEN-1:0]    ent_tgt [DEPTH];
    logic [DEPTH-1:0]   ent_vld;
    logic [DEPTH-1:0]   ent_res;
    logic [DEPTH-1:0]   ent_tkn;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [TID_W:0]     count;
    logic [THREADS-1:0] pending;
    logic               res_err;

    logic               head_live;
    logic               do_alloc;
    logic               do_pop;
    logic               res_hit;
    logic [PTR_W-1:0]   res_idx;
    logic [THREADS-1:0] pend_set;
    logic [THREADS-1:0] pend_clr;

    assign head_live     = !rst && (count != '0);
    assign alloc_ready_o = !rst && (count < DEPTH_C) && !pending[alloc_tid_i];
    assign do_alloc      = alloc_valid_i && alloc_ready_o;
    assign do_pop        = head_live && !stall_i && ent_res[head] && (!ent_tkn[head] || br_ack_i);

    // At most one unresolved entry per thread exists, so the last hit is the only hit.
    always_comb begin
        res_hit = 1'b0;
        res_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && !ent_res[i] && (ent_tid[i] == res_tid_i)) begin
                res_hit = 1'b1;
                res_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (do_alloc) pend_set[alloc_tid_i]   = 1'b1;
        if (do_pop)   pend_clr[ent_tid[head]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pending <= '0;
            res_err <= 1'b0;
            ent_vld <= '0;
            ent_res <= '0;
        end else begin
            res_err <= res_valid_i && !res_hit;
            pending <= (pending & ~pend_clr) | pend_set;
            if (res_valid_i && res_hit) ent_res[res_idx] <= 1'b1;
            if (do_pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (do_alloc) begin
                ent_vld[tail] <= 1'b1;
                ent_res[tail] <= 1'b0;
                tail          <= tail + 1'b1;
            end
            if (do_alloc && !do_pop)      count <= count + 1'b1;
            else if (!do_alloc && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) ent_tid[tail] <= alloc_tid_i;
        if (res_valid_i && res_hit) begin
            ent_tkn[res_idx] <= res_taken_i;
            ent_tgt[res_idx] <= res_target_i;
        end
    end

    assign br_fifo_empty_o = !head_live;
    assign br_thread_id_o  = head_live ? ent_tid[head] : '0;
    assign br_valid_o      = head_live && ent_res[head];
    assign br_true_o       = br_valid_o && ent_tkn[head];
    assign br_pc_o         = br_true_o ? ent_tgt[head] : '0;
    assign pending_o       = pending;
    assign count_o         = count;
    assign res_err_o       = res_err;

endmodule
